// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: load/send handshakes between the pattern sequencer and the NeoPixel driver.
interface pattern_sequencer_if;
    logic       load_valid;
    logic [2:0] load_pixel;
    logic [1:0] load_channel;
    logic [7:0] load_color;
    logic       load_ready;
    logic       send_valid;
    logic       send_ready;
    logic       display_done;
    modport master (
        output load_valid, load_pixel, load_channel, load_color, send_valid,
        input  load_ready, send_ready, display_done
    );
    modport slave (
        input  load_valid, load_pixel, load_channel, load_color, send_valid,
        output load_ready, send_ready, display_done
    );
endinterface

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: walks colour/pixel tables, issues per-entry channel loads, then sends and holds each frame.
// Optional PATTERN_SEQ_ROTATE_EN: each frame starts where the previous one ended instead of at entry 0.
module pattern_sequencer #(
    parameter int NUM_ENTRIES = 63,
    parameter int NUM_PIXELS  = 5,
    parameter int FRAME_DELAY = 1250000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [62:0][7:0]    color_array,
    input  logic [62:0][2:0]    pixel_array,
    input  logic [6:0]          max_num_loads,
    input  logic                go,
    pattern_sequencer_if.master bus,
    output logic                busy,
    output logic [15:0]         frame_count
);
    localparam int HW = FRAME_DELAY > 1 ? $clog2(FRAME_DELAY) : 1;
    localparam logic [5:0] LAST = 6'(NUM_ENTRIES - 1);
    localparam logic [6:0] DEPTH = 7'(NUM_ENTRIES);
    localparam logic [HW-1:0] HOLD_INIT = HW'(FRAME_DELAY - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, HOLD} state_t;

    state_t        state, state_nxt;
    logic [5:0]    idx, base_nxt;
    logic [6:0]    load_cnt, n_lat, n_clamp;
    logic [HW-1:0] hold_cnt;
    logic          pix_ok, start, consume, done_evt, hold_end, last;

    assign n_clamp  = max_num_loads == 7'd0 ? 7'd1 : max_num_loads > DEPTH ? DEPTH : max_num_loads;
    assign pix_ok   = {29'd0, pixel_array[idx]} < 32'(NUM_PIXELS);
    assign last     = load_cnt == n_lat - 7'd1;
    assign hold_end = state == HOLD && hold_cnt == '0;
    assign busy     = state != IDLE;

`ifdef PATTERN_SEQ_ROTATE_EN
    logic [5:0] base;
    logic [6:0] base_sum;
    assign base_sum = {1'b0, base} + n_lat;
    assign base_nxt = !hold_end ? base : base_sum >= DEPTH ? 6'(base_sum - DEPTH) : base_sum[5:0];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) base <= '0;
        else base <= base_nxt;
    end
`else
    assign base_nxt = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        start            = 1'b0;
        consume          = 1'b0;
        done_evt         = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_pixel   = '0;
        bus.load_channel = '0;
        bus.load_color   = '0;
        bus.send_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                start     = go;
                state_nxt = go ? LOAD : IDLE;
            end
            LOAD: begin
                bus.load_valid   = pix_ok;
                bus.load_pixel   = pixel_array[idx];
                bus.load_color   = color_array[idx];
                bus.load_channel = 2'(load_cnt % 7'd3);
                // out-of-range pixel entries are skipped without waiting on the driver
                consume          = !pix_ok || bus.load_ready;
                state_nxt        = consume && last ? SEND : LOAD;
            end
            SEND: begin
                bus.send_valid = 1'b1;
                state_nxt      = bus.send_ready ? WAIT_DONE : SEND;
            end
            WAIT_DONE: begin
                done_evt  = bus.display_done;
                state_nxt = bus.display_done ? HOLD : WAIT_DONE;
            end
            HOLD: begin
                start     = hold_end && go;
                state_nxt = !hold_end ? HOLD : go ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            load_cnt    <= '0;
            n_lat       <= '0;
            hold_cnt    <= '0;
            frame_count <= '0;
        end else begin
            if (start) begin
                n_lat    <= n_clamp;
                idx      <= base_nxt;
                load_cnt <= '0;
            end else if (consume) begin
                idx      <= idx == LAST ? 6'd0 : idx + 6'd1;
                load_cnt <= load_cnt + 7'd1;
            end
            if (done_evt) begin
                frame_count <= frame_count + 16'd1;
                hold_cnt    <= HOLD_INIT;
            end else if (state == HOLD && !hold_end) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized scenarios against a table-walking reference model of pattern_sequencer.
module tb_pattern_sequencer;
    localparam int FD = 5;
    localparam int NE = 63;
    localparam int NP = 5;
`ifdef PATTERN_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [62:0][7:0] color_array;
    logic [62:0][2:0] pixel_array;
    logic [6:0]       max_num_loads;
    logic             go;
    logic             busy;
    logic [15:0]      frame_count;

    pattern_sequencer_if bus();

    pattern_sequencer #(.NUM_ENTRIES(NE), .NUM_PIXELS(NP), .FRAME_DELAY(FD)) dut (
        .clock(clock), .reset(reset), .color_array(color_array), .pixel_array(pixel_array),
        .max_num_loads(max_num_loads), .go(go), .bus(bus.master), .busy(busy), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0, n_bad = 0;
    logic [12:0] obs[$], exp_q[$];
    int          nsend = 0, frames_tb = 0, dcnt = 0, m_base = 0;
    int          stall_at = -1, stall_left = 0, stall_cnt = 0, stall_bad = 0;
    bit          rnd_ready = 0, spur = 0, done_seen = 0, tmo = 0;
    logic [12:0] stall_ref;

    // driver model and load monitor: drive at the falling edge, sample 1ns later
    always @(negedge clock) begin
        logic [12:0] p;
        logic        lr;
        bus.display_done = 1'b0;
        if (dcnt != 0) begin
            dcnt--;
            if (dcnt == 0) begin
                bus.display_done = 1'b1;
                frames_tb++;
                done_seen = 1'b1;
            end
        end else if (spur && $urandom_range(0, 5) == 0) bus.display_done = 1'b1;
        lr = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_at >= 0 && obs.size() == stall_at && bus.load_valid && stall_left > 0) begin
            lr = 1'b0;
            stall_left--;
        end
        bus.load_ready = lr;
        bus.send_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        p = {bus.load_pixel, bus.load_channel, bus.load_color};
        if (bus.load_valid && stall_at >= 0 && obs.size() == stall_at) begin
            if (stall_cnt == 0) stall_ref = p;
            else if (p !== stall_ref) stall_bad++;
            stall_cnt++;
        end
        if (bus.load_valid && bus.load_ready) obs.push_back(p);
        if (bus.send_valid && bus.send_ready) begin
            nsend++;
            dcnt = $urandom_range(1, 4);
        end
    end

    task automatic fill_tables(input int bad_pct);
        for (int i = 0; i < NE; i++) begin
            color_array[i] = 8'($urandom);
            pixel_array[i] = $urandom_range(0, 99) < bad_pct ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        end
    endtask

    // reference: each frame walks n entries from the frame base, loading only in-range pixels
    task automatic model_frames(input int nf, input int mx);
        int n;
        n = mx == 0 ? 1 : (mx > NE ? NE : mx);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < n; k++) begin
                int e;
                e = (m_base + k) % NE;
                if (int'(pixel_array[e]) < NP) exp_q.push_back({pixel_array[e], 2'(k % 3), color_array[e]});
            end
            if (ROT) m_base = (m_base + n) % NE;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #3;
        reset = 1'b0;
        go = 1'b0;
        dcnt = 0;
        rnd_ready = 0;
        spur = 0;
        stall_at = -1;
        repeat (2) @(negedge clock);
        #3;
        reset = 1'b1;
        obs.delete();
        exp_q.delete();
        nsend = 0;
        frames_tb = 0;
        m_base = 0;
        done_seen = 0;
    endtask

    task automatic run_frames(input int nf);
        int target, cyc;
        tmo = 0;
        target = nsend + nf;
        @(negedge clock);
        #3 go = 1'b1;
        cyc = 0;
        while (nsend < target && cyc < 5000) begin
            @(posedge clock);
            cyc++;
        end
        if (cyc >= 5000) tmo = 1;
        @(negedge clock);
        #3 go = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(negedge clock);
            #2;
            cyc++;
        end
        if (cyc >= 5000) tmo = 1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp += 7;
        if (bus.load_valid !== 1'b0) begin n_bad++; $display("FAIL reset_load_valid: got %b want 0", bus.load_valid); end
        if (bus.send_valid !== 1'b0) begin n_bad++; $display("FAIL reset_send_valid: got %b want 0", bus.send_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        if (bus.load_pixel !== 3'd0) begin n_bad++; $display("FAIL reset_load_pixel: got %0d want 0", bus.load_pixel); end
        if (bus.load_channel !== 2'd0) begin n_bad++; $display("FAIL reset_load_channel: got %0d want 0", bus.load_channel); end
        if (bus.load_color !== 8'd0) begin n_bad++; $display("FAIL reset_load_color: got %h want 0", bus.load_color); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        fill_tables(0);
        max_num_loads = 7'd15;
        @(negedge clock);
        #3 go = 1'b1;
        @(negedge clock);
        #2;
        n_cmp += 4;
        if (bus.load_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency_valid: got %b want 1", bus.load_valid); end
        if (bus.load_pixel !== pixel_array[0]) begin n_bad++; $display("FAIL basic_first_pixel: got %0d want %0d", bus.load_pixel, pixel_array[0]); end
        if (bus.load_color !== color_array[0]) begin n_bad++; $display("FAIL basic_first_color: got %h want %h", bus.load_color, color_array[0]); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        run_frames(5);
        model_frames(5, 15);
        n_cmp += 3;
        if (tmo) begin n_bad++; $display("FAIL basic_timeout: got timeout want completion"); end
        if (frame_count !== 16'd5) begin n_bad++; $display("FAIL basic_frame_count: got %0d want 5", frame_count); end
        if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        fill_tables(10);
        rnd_ready = 1;
        spur = 1;
        max_num_loads = 7'd0;
        run_frames(2);
        model_frames(2, 0);
        max_num_loads = 7'd100;
        run_frames(1);
        model_frames(1, 100);
        n_cmp += 3;
        if (tmo) begin n_bad++; $display("FAIL clamp_timeout: got timeout want completion"); end
        if (frame_count !== 16'(frames_tb)) begin n_bad++; $display("FAIL clamp_frame_count: got %0d want %0d", frame_count, frames_tb); end
        if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL clamp_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL clamp_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_skip();
        do_reset();
        fill_tables(0);
        pixel_array[3] = 3'd6;
        max_num_loads = 7'd15;
        run_frames(1);
        model_frames(1, 15);
        n_cmp += 2;
        if (tmo) begin n_bad++; $display("FAIL skip_timeout: got timeout want completion"); end
        if (obs.size() !== 14) begin n_bad++; $display("FAIL skip_count: got %0d want 14", obs.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL skip_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
        obs.delete();
        exp_q.delete();
        fill_tables(30);
        rnd_ready = 1;
        spur = 1;
        max_num_loads = 7'($urandom_range(5, 40));
        run_frames(3);
        model_frames(3, int'(max_num_loads));
        n_cmp += 2;
        if (tmo) begin n_bad++; $display("FAIL skip_rand_timeout: got timeout want completion"); end
        if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL skip_rand_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL skip_rand_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        fill_tables(0);
        max_num_loads = 7'd15;
        stall_cnt = 0;
        stall_bad = 0;
        stall_left = 4;
        stall_at = 2;
        run_frames(1);
        stall_at = -1;
        model_frames(1, 15);
        n_cmp += 4;
        if (tmo) begin n_bad++; $display("FAIL stall_timeout: got timeout want completion"); end
        if (stall_cnt !== 5) begin n_bad++; $display("FAIL stall_cycles: got %0d want 5", stall_cnt); end
        if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
        if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_tables(0);
        max_num_loads = 7'd20;
        run_frames(1);
        @(negedge clock);
        #3 go = 1'b1;
        repeat (3) @(negedge clock);
        #3;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        reset = 1'b0;
        dcnt = 0;
        #1;
        n_cmp += 6;
        if (bus.load_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_load_valid: got %b want 0", bus.load_valid); end
        if (bus.load_pixel !== 3'd0) begin n_bad++; $display("FAIL rmid_load_pixel: got %0d want 0", bus.load_pixel); end
        if (bus.load_color !== 8'd0) begin n_bad++; $display("FAIL rmid_load_color: got %h want 0", bus.load_color); end
        if (bus.send_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_send_valid: got %b want 0", bus.send_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (frame_count !== 16'd0) begin n_bad++; $display("FAIL rmid_frame_count: got %0d want 0", frame_count); end
        @(negedge clock);
        #3;
        reset = 1'b1;
        obs.delete();
        exp_q.delete();
        nsend = 0;
        frames_tb = 0;
        m_base = 0;
        @(negedge clock);
        #2;
        n_cmp += 2;
        if (bus.load_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_restart_valid: got %b want 1", bus.load_valid); end
        if (bus.load_pixel !== pixel_array[0]) begin n_bad++; $display("FAIL rmid_restart_pixel: got %0d want %0d", bus.load_pixel, pixel_array[0]); end
        run_frames(1);
        model_frames(1, 20);
        n_cmp += 2;
        if (tmo) begin n_bad++; $display("FAIL rmid_timeout: got timeout want completion"); end
        if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL rmid_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL rmid_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_stop();
        int cyc;
        do_reset();
        fill_tables(0);
        max_num_loads = 7'd7;
        @(negedge clock);
        #3 go = 1'b1;
        cyc = 0;
        while (nsend < 1 && cyc < 500) begin
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        #3 go = 1'b0;
        cyc = 0;
        while (!done_seen && cyc < 500) begin
            @(negedge clock);
            #2;
            cyc++;
        end
        n_cmp++;
        if (!done_seen) begin n_bad++; $display("FAIL stop_done_timeout: got timeout want display_done"); end
        cyc = 0;
        while (busy && cyc < 500) begin
            @(negedge clock);
            #2;
            cyc++;
        end
        model_frames(1, 7);
        n_cmp += 3;
        if (cyc !== FD + 1) begin n_bad++; $display("FAIL stop_hold_len: got %0d want %0d", cyc, FD + 1); end
        if (frame_count !== 16'd1) begin n_bad++; $display("FAIL stop_frame_count: got %0d want 1", frame_count); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy); end
        run_frames(1);
        model_frames(1, 7);
        n_cmp += 2;
        if (tmo) begin n_bad++; $display("FAIL stop_timeout: got timeout want completion"); end
        if (obs.size() !== exp_q.size()) begin n_bad++; $display("FAIL stop_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL stop_load[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        go = 1'b0;
        max_num_loads = 7'd0;
        color_array = '0;
        pixel_array = '0;
        bus.load_ready = 1'b1;
        bus.send_ready = 1'b1;
        bus.display_done = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_skip();
        test_stall();
        test_reset_mid();
        test_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
